key_debounce_2ch: RTL
=====================

KEY_DEBOUNCE_2CH -- requirements
Module: key_debounce_2ch

Interface
REQ-001 Parameter CNT_MAX, default 20'd999_999, is the debounce filter terminal count (20 ms at 50 MHz).
REQ-002 Parameter REPEAT_DLY, default 26'd49_999_999, is the hold time before the first auto-repeat pulse (1 s); it is used only with KEY_REPEAT_EN.
REQ-003 Parameter REPEAT_PER, default 26'd9_999_999, is the auto-repeat period (200 ms); it is used only with KEY_REPEAT_EN.
REQ-004 clk  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 key_in  input  2  raw push-button levels, active-low, asynchronous to clk; bit0 is the 1-yuan coin key and bit1 is the 0.5-yuan coin key.
REQ-007 key_flag  output  2  one-cycle press pulses, one bit per channel, consumed by the coin-counting FSM.
REQ-008 key_level  output  2  debounced key state per channel; 1 = pressed.

Function
REQ-009 Each key_in bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each channel SHALL run an independent 4-state FSM with states UP, DN_FILT, DOWN and UP_FILT, plus its own 20-bit counter.
REQ-011 Transitions from UP: a synchronized low moves the channel to DN_FILT and clears the counter to 0.
REQ-012 Transitions from DN_FILT: a synchronized high returns the channel to UP (bounce); reaching counter==CNT_MAX moves it to DOWN and raises a press request; otherwise the counter increments by 1.
REQ-013 Transitions from DOWN: a synchronized high moves the channel to UP_FILT with the counter cleared.
REQ-014 Transitions from UP_FILT: a synchronized low returns the channel to DOWN with no pulse; reaching counter==CNT_MAX moves it to UP; otherwise the counter increments by 1.
REQ-015 The counter SHALL saturate and never wrap; any glitch shorter than CNT_MAX+1 cycles SHALL produce no pulse.
REQ-016 key_level[i] SHALL be 1 in states DOWN and UP_FILT and 0 in states UP and DN_FILT.
REQ-017 Latency: if key_in[i] is first sampled low at edge k and stays low, key_flag[i] SHALL be high for exactly the one cycle following edge k+CNT_MAX+4.
REQ-018 The block SHALL never assert both key_flag bits in the same cycle.
REQ-019 If both channels raise press requests in the same cycle, key_flag[0] SHALL fire first and key_flag[1] SHALL fire on the next cycle from a 1-deep pending register.
REQ-020 A pending channel-1 request SHALL fire even if key_in[1] releases during the deferral cycle.
REQ-021 Release SHALL never generate a pulse.
REQ-022 Each press SHALL produce exactly one pulse when KEY_REPEAT_EN is undefined.

Reset
REQ-023 While rst_n is low, both FSMs SHALL be in UP, and the counters, synchronizers (set to 1), pending register, key_flag (2'b00) and key_level (2'b00) SHALL hold their reset values.
REQ-024 Reset asserted mid-filter or mid-press SHALL discard all state; after release, a still-held key SHALL re-filter through the full CNT_MAX+4 cycles and produce one new pulse.
REQ-025 Outputs SHALL be registered and glitch-free from the first clock after reset release.

Configuration
REQ-026 Macro KEY_REPEAT_EN, when defined, SHALL add a per-channel 26-bit repeat counter that is active only in DOWN.
REQ-027 With KEY_REPEAT_EN defined, the first repeat pulse SHALL occur REPEAT_DLY+1 cycles after entering DOWN, and subsequent pulses every REPEAT_PER+1 cycles.
REQ-028 With KEY_REPEAT_EN defined, repeat pulses SHALL obey the same arbitration as REQ-018 to REQ-020, and the repeat counter SHALL reset on leaving DOWN.
REQ-029 Without KEY_REPEAT_EN, the repeat counters and their logic SHALL be absent and the behaviour is that of REQ-022.

Verification (CNT_MAX=9, REPEAT_DLY=49, REPEAT_PER=19)
REQ-030 key_in=2'b10 from edge 5, held for 40 cycles -> key_flag=2'b01 for exactly one cycle after edge 18, key_level[0]=1 from edge 18, no pulse on release.
REQ-031 key_in[1] bounces with low pulses of 3, 5 and 8 cycles, then holds low -> exactly one key_flag[1] pulse, 13 cycles after the start of the stable low.
REQ-032 Both keys go low on the same edge -> key_flag=2'b01, then 2'b10 on the next cycle, never 2'b11.
REQ-033 rst_n pulled low at counter==6 in DN_FILT with the key still held, then released -> no pulse from the interrupted filter, then one pulse CNT_MAX+4 cycles after reset release.
REQ-034 KEY_REPEAT_EN defined, key[0] held for 120 cycles -> pulses at the initial press, +50 cycles, then every 20 cycles while held; KEY_REPEAT_EN undefined -> a single pulse only.

Source files
------------

// File: rtl/key_debounce_2ch.sv
// Two-channel push-button debouncer with arbitrated one-cycle press pulses.
// Define KEY_REPEAT_EN to add hold-to-repeat pulses on each channel.
module key_debounce_2ch #(
  parameter logic [19:0] CNT_MAX    = 20'd999_999,
  parameter logic [25:0] REPEAT_DLY = 26'd49_999_999,
  parameter logic [25:0] REPEAT_PER = 26'd9_999_999
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] key_in,
  output logic [1:0] key_flag,
  output logic [1:0] key_level
);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DN_FILT = 2'd1,
    DOWN    = 2'd2,
    UP_FILT = 2'd3
  } state_e;

  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  state_e      state_q [2];
  logic [19:0] cnt_q   [2];
  logic [1:0]  req_q;
  logic [1:0]  level_q;
  logic [1:0]  flag_q;
  logic        pending_q;
  logic [1:0]  flag_d;
  logic        pending_d;

`ifdef KEY_REPEAT_EN
  logic [25:0] rpt_q   [2];
  logic [1:0]  first_q;
`endif

  // Raw keys are asynchronous; idle level of the synchronizer is released (high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= UP;
        cnt_q[i]   <= '0;
`ifdef KEY_REPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
      req_q   <= 2'b00;
      level_q <= 2'b00;
`ifdef KEY_REPEAT_EN
      first_q <= 2'b11;
`endif
    end else begin
      for (int i = 0; i < 2; i++) begin
        req_q[i]   <= 1'b0;
        level_q[i] <= (state_q[i] == DOWN) || (state_q[i] == UP_FILT);
        case (state_q[i])
          UP: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DN_FILT;
              cnt_q[i]   <= '0;
            end
          end
          DN_FILT: begin
            if (sync2_q[i]) begin
              state_q[i] <= UP;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= DOWN;
              req_q[i]   <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + 20'd1;
            end
          end
          DOWN: begin
            if (sync2_q[i]) begin
              state_q[i] <= UP_FILT;
              cnt_q[i]   <= '0;
            end
          end
          UP_FILT: begin
            if (!sync2_q[i]) begin
              state_q[i] <= DOWN;
            end else if (cnt_q[i] == CNT_MAX) begin
              state_q[i] <= UP;
            end else begin
              cnt_q[i] <= cnt_q[i] + 20'd1;
            end
          end
          default: state_q[i] <= UP;
        endcase
`ifdef KEY_REPEAT_EN
        // Repeat timer runs only while settled in DOWN; any other state rearms the long first delay.
        if ((state_q[i] == DOWN) && !sync2_q[i]) begin
          if (rpt_q[i] == (first_q[i] ? REPEAT_DLY : REPEAT_PER)) begin
            req_q[i]   <= 1'b1;
            rpt_q[i]   <= '0;
            first_q[i] <= 1'b0;
          end else begin
            rpt_q[i] <= rpt_q[i] + 26'd1;
          end
        end else begin
          rpt_q[i]   <= '0;
          first_q[i] <= 1'b1;
        end
`endif
      end
    end
  end

  // Channel 0 wins a simultaneous request; channel 1 is held one cycle and then always fires.
  always_comb begin
    flag_d    = 2'b00;
    pending_d = 1'b0;
    flag_d[0] = req_q[0];
    flag_d[1] = (req_q[1] | pending_q) & ~req_q[0];
    pending_d = (req_q[1] | pending_q) & req_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q    <= 2'b00;
      pending_q <= 1'b0;
    end else begin
      flag_q    <= flag_d;
      pending_q <= pending_d;
    end
  end

  assign key_flag  = flag_q;
  assign key_level = level_q;

endmodule
